// File: rtl/register_file_banked_if.sv
`default_nettype none
// ============================================================================
// Module   : register_file_banked_if
// Purpose  : Bus bundle between the decoder/ALU and the banked register file.
// Revision : 1.0
// ============================================================================
interface register_file_banked_if #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 5,
   parameter int NUM_BANKS = 4,
   parameter int FLAG_BITS = 7
);
   localparam int CTX_W = $clog2(NUM_BANKS + 1);

   logic                 enable;
   logic [ADDR_W-1:0]    a_addr;
   logic [DATA_W-1:0]    a_data_out;
   logic [ADDR_W-1:0]    b_addr;
   logic [DATA_W-1:0]    b_data_in;
   logic                 b_wr_enable;
   logic [DATA_W-1:0]    b_data_out;
   logic [FLAG_BITS-1:0] flag_inputs;
   logic [FLAG_BITS-1:0] flag_clear;
   logic                 ctx_push;
   logic                 ctx_pop;
   logic [CTX_W-1:0]     ctx_depth;
   logic                 ctx_full;
   logic                 ctx_empty;
   logic                 ctx_error;
   logic [DATA_W-1:0]    reg_gout;
   logic [DATA_W-1:0]    reg_dout;
   logic [DATA_W-1:0]    reg_flag;

   modport master (
      output enable, a_addr, b_addr, b_data_in, b_wr_enable,
             flag_inputs, flag_clear, ctx_push, ctx_pop,
      input  a_data_out, b_data_out, ctx_depth, ctx_full, ctx_empty,
             ctx_error, reg_gout, reg_dout, reg_flag
   );

   modport slave (
      input  enable, a_addr, b_addr, b_data_in, b_wr_enable,
             flag_inputs, flag_clear, ctx_push, ctx_pop,
      output a_data_out, b_data_out, ctx_depth, ctx_full, ctx_empty,
             ctx_error, reg_gout, reg_dout, reg_flag
   );
endinterface
`default_nettype wire

// File: rtl/register_file_banked.sv
`default_nettype none
// ============================================================================
// Module   : register_file_banked
// Purpose  : Banked CPU register file with shared GOUT/DOUT/FLAG and a
//            push/pop context pointer.
// Revision : 1.0
// ============================================================================
module register_file_banked #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 5,
   parameter int NUM_BANKS = 4,
   parameter int FLAG_BITS = 7,
   parameter int GOUT_ADDR = 29,
   parameter int DOUT_ADDR = 30,
   parameter int FLAG_ADDR = 31,
   parameter bit BYPASS    = 1'b1
) (
   input  wire logic              clk,
   input  wire logic              reset,
   register_file_banked_if.slave  bus
);
   localparam int                CTX_W    = $clog2(NUM_BANKS + 1);
   localparam int                BANK_W   = $clog2(NUM_BANKS);
   localparam int                NUM_REGS = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] C_GOUT   = ADDR_W'(GOUT_ADDR);
   localparam logic [ADDR_W-1:0] C_DOUT   = ADDR_W'(DOUT_ADDR);
   localparam logic [ADDR_W-1:0] C_FLAG   = ADDR_W'(FLAG_ADDR);
   localparam logic [CTX_W-1:0]  C_TOP    = CTX_W'(NUM_BANKS - 1);

   logic [DATA_W-1:0]    r_bank [NUM_BANKS][NUM_REGS];
   logic [DATA_W-1:0]    r_gout;
   logic [DATA_W-1:0]    r_dout;
   logic [FLAG_BITS-1:0] r_flag;
   logic [CTX_W-1:0]     r_depth;
   logic                 r_ctx_error;

   logic                 w_wr;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic [BANK_W-1:0]    w_bank;

   assign w_full  = (r_depth == C_TOP);
   assign w_empty = (r_depth == '0);
   assign w_bank  = r_depth[BANK_W-1:0];
   assign w_wr    = bus.enable & bus.b_wr_enable & (bus.b_addr != C_FLAG);
   // Simultaneous push and pop cancel out and never count as an error.
   assign w_push  = bus.enable & bus.ctx_push & ~bus.ctx_pop;
   assign w_pop   = bus.enable & bus.ctx_pop  & ~bus.ctx_push;

   function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] addr);
      if (BYPASS && w_wr && (addr == bus.b_addr))
         return bus.b_data_in;
      else if (addr == C_GOUT)
         return r_gout;
      else if (addr == C_DOUT)
         return r_dout;
      else if (addr == C_FLAG)
         return DATA_W'(r_flag);
      else
         return r_bank[w_bank][addr];
   endfunction

   assign bus.a_data_out = f_read(bus.a_addr);
   assign bus.b_data_out = f_read(bus.b_addr);
   assign bus.ctx_depth  = r_depth;
   assign bus.ctx_full   = w_full;
   assign bus.ctx_empty  = w_empty;
   assign bus.ctx_error  = r_ctx_error;
   assign bus.reg_gout   = r_gout;
   assign bus.reg_dout   = r_dout;
   assign bus.reg_flag   = DATA_W'(r_flag);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < NUM_BANKS; b++)
            for (int r = 0; r < NUM_REGS; r++)
               r_bank[b][r] <= '0;
         r_gout      <= '0;
         r_dout      <= '0;
         r_flag      <= '0;
         r_depth     <= '0;
         r_ctx_error <= 1'b0;
      end else begin
         // The write lands in the bank selected before this cycle's push/pop.
         if (w_wr) begin
            if (bus.b_addr == C_GOUT)
               r_gout <= bus.b_data_in;
            else if (bus.b_addr == C_DOUT)
               r_dout <= bus.b_data_in;
            else
               r_bank[w_bank][bus.b_addr] <= bus.b_data_in;
         end
         r_flag      <= (r_flag & ~bus.flag_clear) | bus.flag_inputs;
         r_ctx_error <= (w_push & w_full) | (w_pop & w_empty);
         if (w_push & ~w_full)
            r_depth <= r_depth + CTX_W'(1);
         else if (w_pop & ~w_empty)
            r_depth <= r_depth - CTX_W'(1);
      end
   end
endmodule
`default_nettype wire
